// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: req/ack data bus with byte lanes, load extension, timeout and misalign flags.
// Latency: IDLE, then BUS until ack or timeout, then DONE (3 cycles minimum). Stalls the pipeline while the bus is outstanding.
module mem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_M,
    input  logic              mem_write_M,
    input  logic [1:0]        size_M,
    input  logic              sign_ext_M,
    input  logic [DATA_W-1:0] addr_M,
    input  logic [DATA_W-1:0] wdata_M,
    output logic              stall_M,
    output logic [DATA_W-1:0] memory_data_out,
    output logic              misalign_M,
    output logic              bus_err_M,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        size_q;
    logic [1:0]        lo_q;
    logic              sign_q;

    logic              access;
    logic              misaligned;
    logic              start;
    logic [3:0]        be_next;
    logic [DATA_W-1:0] wdata_next;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_data;

    always_comb begin
        access = mem_read_M | mem_write_M;
        case (size_M)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_M[0];
            default: misaligned = |addr_M[1:0];
        endcase
        start = (state == IDLE) && access && !misaligned;
    end

    // Reset overrides the combinational start so the pipeline never stalls under reset.
    assign stall_M = !rst && (start || (state == BUS));

    always_comb begin
        case (size_M)
            2'b00: begin
                be_next    = 4'b0001 << addr_M[1:0];
                wdata_next = {4{wdata_M[7:0]}};
            end
            2'b01: begin
                be_next    = addr_M[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata_M[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = wdata_M;
            end
        endcase
    end

    always_comb begin
        byte_sel = bus_rdata[{lo_q, 3'b000} +: 8];
        half_sel = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (size_q)
            2'b00:   load_data = {{(DATA_W-8){sign_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{(DATA_W-16){sign_q & half_sel[15]}}, half_sel};
            default: load_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            size_q          <= '0;
            lo_q            <= '0;
            sign_q          <= 1'b0;
            memory_data_out <= '0;
            misalign_M      <= 1'b0;
            bus_err_M       <= 1'b0;
            bus_req         <= 1'b0;
            bus_we          <= 1'b0;
            bus_addr        <= '0;
            bus_be          <= '0;
            bus_wdata       <= '0;
        end else begin
            misalign_M <= 1'b0;
            bus_err_M  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= BUS;
                        cnt       <= '0;
                        size_q    <= size_M;
                        lo_q      <= addr_M[1:0];
                        sign_q    <= sign_ext_M;
                        bus_req   <= 1'b1;
                        bus_we    <= !mem_read_M;
                        bus_addr  <= {addr_M[DATA_W-1:2], 2'b00};
                        bus_be    <= be_next;
                        bus_wdata <= wdata_next;
                    end else if (access) begin
                        misalign_M <= 1'b1;
                    end
                end
                BUS: begin
                    // Ack is checked first so a last-cycle ack beats the timeout.
                    if (bus_ack) begin
                        if (!bus_we) memory_data_out <= load_data;
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        if (!bus_we) memory_data_out <= '0;
                        bus_err_M <= 1'b1;
                        bus_req   <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: table of accesses driven through a responder, expectations queued and checked on completion.
module tb_mem_access_ctrl;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_M, mem_write_M, sign_ext_M;
    logic [1:0]  size_M;
    logic [31:0] addr_M, wdata_M;
    logic        stall_M, misalign_M, bus_err_M;
    logic [31:0] memory_data_out;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_read_M(mem_read_M), .mem_write_M(mem_write_M),
        .size_M(size_M), .sign_ext_M(sign_ext_M),
        .addr_M(addr_M), .wdata_M(wdata_M),
        .stall_M(stall_M), .memory_data_out(memory_data_out),
        .misalign_M(misalign_M), .bus_err_M(bus_err_M),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        rd, wr;
        logic [1:0]  size;
        logic        sx;
        logic [31:0] addr, wdata, rdata;
        int          dly;   // BUS cycle index of the ack, -1 = never
        logic        mis, err;
        logic [31:0] out;
        logic [3:0]  be;
        logic [31:0] wd, ba;
        logic        we;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic [1:0] size, input logic sx,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       input int dly, input logic mis, input logic err, input logic [31:0] out,
                       input logic [3:0] be, input logic [31:0] wd, input logic [31:0] ba, input logic we);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = size; v.sx = sx; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.dly = dly; v.mis = mis; v.err = err; v.out = out;
        v.be = be; v.wd = wd; v.ba = ba; v.we = we;
        tbl.push_back(v);
    endtask

    task automatic drop_inputs();
        mem_read_M = 1'b0; mem_write_M = 1'b0; bus_ack = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        vec_t        e;
        int          stalls, k, exp_stall;
        logic        seen, stable, done;
        logic [31:0] a0, w0;
        logic [3:0]  b0;
        logic        we0;
        @(posedge clk); #1;
        mem_read_M = v.rd; mem_write_M = v.wr; size_M = v.size; sign_ext_M = v.sx;
        addr_M = v.addr; wdata_M = v.wdata; bus_ack = 1'b0;
        sb.push_back(v);
        stalls = 0; k = 0; seen = 1'b0; stable = 1'b1; done = 1'b0;
        a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            if (stall_M) stalls++;
            if (bus_req) begin
                if (!seen) begin
                    a0 = bus_addr; w0 = bus_wdata; b0 = bus_be; we0 = bus_we;
                end else if (a0 !== bus_addr || w0 !== bus_wdata || b0 !== bus_be || we0 !== bus_we) begin
                    stable = 1'b0;
                end
                seen = 1'b1;
                if (k == v.dly) begin
                    bus_ack = 1'b1; bus_rdata = v.rdata;
                end else begin
                    bus_ack = 1'b0; bus_rdata = ~v.rdata;
                end
                k++;
            end else if (misalign_M || seen) begin
                done = 1'b1;
                drop_inputs();
                e = sb.pop_front();
                exp_stall = e.mis ? 0 : 1 + ((e.dly < 0 || e.dly >= TO) ? TO : e.dly + 1);
                chk("misalign", misalign_M, e.mis);
                chk("bus_err", bus_err_M, e.err);
                chk("data_out", memory_data_out, e.out);
                chk("stall_cycles", stalls, exp_stall);
                chk("req_seen", seen, !e.mis);
                if (!e.mis) begin
                    chk("bus_be", bus_be, e.be);
                    chk("bus_wdata", bus_wdata, e.wd);
                    chk("bus_we", bus_we, e.we);
                    chk("bus_addr", bus_addr, e.ba);
                    chk("bus_stable", stable, 1'b1);
                end
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL completion_timeout: no completion for addr %h within 64 cycles", v.addr);
            drop_inputs();
            e = sb.pop_front();
        end
    endtask

    initial begin
        logic [31:0] held;
        rst = 1'b1;
        mem_read_M = 0; mem_write_M = 0; size_M = 0; sign_ext_M = 0;
        addr_M = 0; wdata_M = 0; bus_ack = 0; bus_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", stall_M, 0);
        chk("rst_data_out", memory_data_out, 0);
        chk("rst_misalign", misalign_M, 0);
        chk("rst_bus_err", bus_err_M, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        rst = 1'b0;

        //   rd wr size sx addr        wdata        rdata        dly mis err out           be       wd           ba           we
        add(1, 0, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF,  0, 0, 0, 32'hDEADBEEF, 4'b1111, 32'h0,        32'h100, 0);
        add(1, 0, 2'b00, 1, 32'h103, 32'h0,        32'h80112233,  0, 0, 0, 32'hFFFFFF80, 4'b1000, 32'h0,        32'h100, 0);
        add(1, 0, 2'b00, 0, 32'h103, 32'h0,        32'h80112233,  0, 0, 0, 32'h00000080, 4'b1000, 32'h0,        32'h100, 0);
        add(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h0,         1, 0, 0, 32'h00000080, 4'b1100, 32'hABCDABCD, 32'h200, 1);
        add(1, 0, 2'b10, 0, 32'h101, 32'h0,        32'h0,         0, 1, 0, 32'h00000080, 4'b0,    32'h0,        32'h0,   0);
        add(1, 0, 2'b01, 1, 32'h102, 32'h0,        32'h80011234,  2, 0, 0, 32'hFFFF8001, 4'b1100, 32'h0,        32'h100, 0);
        add(1, 0, 2'b01, 0, 32'h100, 32'h0,        32'h8001F234,  0, 0, 0, 32'h0000F234, 4'b0011, 32'h0,        32'h100, 0);
        add(1, 0, 2'b00, 0, 32'h001, 32'h0,        32'h112233C4,  0, 0, 0, 32'h00000033, 4'b0010, 32'h0,        32'h0,   0);
        add(0, 1, 2'b00, 0, 32'h0A2, 32'h123456A5, 32'h0,         0, 0, 0, 32'h00000033, 4'b0100, 32'hA5A5A5A5, 32'hA0,  1);
        add(0, 1, 2'b11, 0, 32'h010, 32'hCAFEF00D, 32'h0,         3, 0, 0, 32'h00000033, 4'b1111, 32'hCAFEF00D, 32'h10,  1);
        add(0, 1, 2'b01, 0, 32'h001, 32'h0,        32'h0,         0, 1, 0, 32'h00000033, 4'b0,    32'h0,        32'h0,   0);
        add(1, 0, 2'b11, 0, 32'h00E, 32'h0,        32'h0,         0, 1, 0, 32'h00000033, 4'b0,    32'h0,        32'h0,   0);
        add(1, 1, 2'b10, 0, 32'h020, 32'h99999999, 32'h01020304,  0, 0, 0, 32'h01020304, 4'b1111, 32'h99999999, 32'h20,  0);
        add(1, 0, 2'b00, 0, 32'h002, 32'h0,        32'h00FF0000,  0, 0, 0, 32'h000000FF, 4'b0100, 32'h0,        32'h0,   0);
        add(1, 0, 2'b00, 1, 32'h002, 32'h0,        32'h00FF0000,  0, 0, 0, 32'hFFFFFFFF, 4'b0100, 32'h0,        32'h0,   0);
        add(1, 0, 2'b10, 0, 32'h040, 32'h0,        32'h12345678, -1, 0, 1, 32'h00000000, 4'b1111, 32'h0,        32'h40,  0);
        add(1, 0, 2'b10, 0, 32'h044, 32'h0,        32'h55AA55AA, 15, 0, 0, 32'h55AA55AA, 4'b1111, 32'h0,        32'h44,  0);
        add(0, 1, 2'b00, 0, 32'h007, 32'h0000007E, 32'h0,         0, 0, 0, 32'h55AA55AA, 4'b1000, 32'h7E7E7E7E, 32'h4,   1);
        foreach (tbl[i]) apply(tbl[i]);

        // Ack while idle must not disturb the held load result.
        held = 32'h55AA55AA;
        @(posedge clk); #1;
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        chk("idle_ack_req", bus_req, 0);
        chk("idle_ack_stall", stall_M, 0);
        chk("idle_ack_data", memory_data_out, held);
        bus_ack = 1'b0;

        // Reset on the third BUS cycle abandons the access.
        @(posedge clk); #1;
        mem_read_M = 1'b1; size_M = 2'b10; sign_ext_M = 1'b0; addr_M = 32'h200;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_rst_req", bus_req, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_req", bus_req, 0);
        chk("abort_stall", stall_M, 0);
        chk("abort_err", bus_err_M, 0);
        chk("abort_misalign", misalign_M, 0);
        chk("abort_be", bus_be, 0);
        chk("abort_data", memory_data_out, 0);
        mem_read_M = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        tbl.delete();
        add(1, 0, 2'b01, 0, 32'h004, 32'h0, 32'h7FFF0000, 0, 0, 0, 32'h00000000, 4'b0011, 32'h0, 32'h4, 0);
        add(1, 0, 2'b01, 1, 32'h006, 32'h0, 32'h7FFF0000, 0, 0, 0, 32'h00007FFF, 4'b1100, 32'h0, 32'h4, 0);
        foreach (tbl[i]) apply(tbl[i]);

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
